// File: rtl/omega8_pkg.sv
// Shared definitions for the omega8 operand-fetch slice: default widths
// and the fetch FSM state encoding.
package omega8_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DATA  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/omega8_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at handoff of a writing
// instruction, cleared by writeback; three combinational lookup ports.
module omega8_scoreboard
    import omega8_pkg::*;
#(
    parameter int ADDR_W   = omega8_pkg::ADDR_W,
    parameter int NUM_REGS = omega8_pkg::NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    input  logic [ADDR_W-1:0] i_look_addr_a,
    input  logic [ADDR_W-1:0] i_look_addr_b,
    input  logic [ADDR_W-1:0] i_look_addr_c,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_busy_c
);

    logic [NUM_REGS-1:0] pending_q;

    // NOTE: pending_q is control state, not storage -- every bit must be reset
    // or a stale bit would stall the first reader forever.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pending_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // Set has priority so a same-edge writeback cannot lose a new claim.
                if (i_set_en && i_set_addr == ADDR_W'(i)) begin
                    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
                    pending_q[i] <= 1'b1;
                end else if (i_clr_en && i_clr_addr == ADDR_W'(i)) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the loop leaves an output unassigned.
        o_busy_a = 1'b0;
        o_busy_b = 1'b0;
        o_busy_c = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_look_addr_a == ADDR_W'(i)) o_busy_a = pending_q[i];
            if (i_look_addr_b == ADDR_W'(i)) o_busy_b = pending_q[i];
            if (i_look_addr_c == ADDR_W'(i)) o_busy_c = pending_q[i];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction, waits out RAW/WAW hazards,
// reads the register file, forwards writeback data and hands operands to execute.
module operand_fetch
    import omega8_pkg::*;
#(
    parameter int DATA_W   = omega8_pkg::DATA_W,
    parameter int ADDR_W   = omega8_pkg::ADDR_W,
    parameter int NUM_REGS = omega8_pkg::NUM_REGS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_instr_valid,
    output logic              o_instr_ready,
    input  logic [ADDR_W-1:0] i_rs1,
    input  logic [ADDR_W-1:0] i_rs2,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_wr_en,
    output logic [ADDR_W-1:0] o_rf_r_address1,
    output logic [ADDR_W-1:0] o_rf_r_address2,
    output logic              o_rf_read,
    input  logic [DATA_W-1:0] i_rf_data1,
    input  logic [DATA_W-1:0] i_rf_data2,
    output logic [ADDR_W-1:0] o_rf_w_address,
    output logic [DATA_W-1:0] o_rf_w_data,
    output logic              o_rf_write,
    output logic              o_op_valid,
    input  logic              i_op_ready,
    output logic [DATA_W-1:0] o_op_a,
    output logic [DATA_W-1:0] o_op_b,
    output logic [ADDR_W-1:0] o_op_rd,
    output logic              o_op_wr_en,
    input  logic              i_wb_valid,
    input  logic [ADDR_W-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data
);

    fetch_state_e state_q, state_d;

    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic              wr_en_q;
    logic              fwd1_q, fwd2_q;
    logic [DATA_W-1:0] fwd_data_q;

    logic accept, read_fire, op_load, handoff;
    logic busy_rs1, busy_rs2, busy_rd, hazard;
    logic wb_hit1, wb_hit2;

    assign hazard  = busy_rs1 | busy_rs2 | (wr_en_q & busy_rd);
    assign wb_hit1 = i_wb_valid && (i_wb_rd == rs1_q);
    assign wb_hit2 = i_wb_valid && (i_wb_rd == rs2_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        read_fire = 1'b0;
        op_load   = 1'b0;
        handoff   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_instr_valid) begin
                    accept  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!hazard) begin
                    read_fire = 1'b1;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                op_load = 1'b1;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (i_op_ready) begin
                    handoff = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_instr_ready   = (state_q == ST_IDLE);
    assign o_op_valid      = (state_q == ST_VALID);
    assign o_rf_read       = read_fire;
    assign o_rf_r_address1 = read_fire ? rs1_q : '0;
    assign o_rf_r_address2 = read_fire ? rs2_q : '0;

    // Writeback is a pure pass-through to the register file write port.
    assign o_rf_write     = i_wb_valid;
    assign o_rf_w_address = i_wb_rd;
    assign o_rf_w_data    = i_wb_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            wr_en_q <= 1'b0;
        end else if (accept) begin
            rs1_q   <= i_rs1;
            rs2_q   <= i_rs2;
            rd_q    <= i_rd;
            wr_en_q <= i_wr_en;
        end
    end

    // A writeback on the read edge lands after the file was sampled, so the
    // register file returns the old value; remember the bypass for DATA.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fwd1_q     <= 1'b0;
            fwd2_q     <= 1'b0;
            fwd_data_q <= '0;
        end else if (read_fire) begin
            fwd1_q     <= wb_hit1;
            fwd2_q     <= wb_hit2;
            fwd_data_q <= i_wb_data;
        end
    end

    // A writeback during DATA is newer than anything captured on the read edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_op_a     <= '0;
            o_op_b     <= '0;
            o_op_rd    <= '0;
            o_op_wr_en <= 1'b0;
        end else if (op_load) begin
            o_op_a     <= wb_hit1 ? i_wb_data : (fwd1_q ? fwd_data_q : i_rf_data1);
            o_op_b     <= wb_hit2 ? i_wb_data : (fwd2_q ? fwd_data_q : i_rf_data2);
            o_op_rd    <= rd_q;
            o_op_wr_en <= wr_en_q;
        end
    end

    omega8_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_set_en      (handoff & o_op_wr_en),
        .i_set_addr    (o_op_rd),
        .i_clr_en      (i_wb_valid),
        .i_clr_addr    (i_wb_rd),
        .i_look_addr_a (rs1_q),
        .i_look_addr_b (rs2_q),
        .i_look_addr_c (rd_q),
        .o_busy_a      (busy_rs1),
        .o_busy_b      (busy_rs2),
        .o_busy_c      (busy_rd)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a small registered register-file model
// plus hand-computed expectations for issue, stall, forwarding and reset.
module tb_operand_fetch;

    logic       i_clk;
    logic       i_rst;
    logic       i_instr_valid;
    logic       o_instr_ready;
    logic [2:0] i_rs1, i_rs2, i_rd;
    logic       i_wr_en;
    logic [2:0] o_rf_r_address1, o_rf_r_address2;
    logic       o_rf_read;
    logic [7:0] i_rf_data1, i_rf_data2;
    logic [2:0] o_rf_w_address;
    logic [7:0] o_rf_w_data;
    logic       o_rf_write;
    logic       o_op_valid;
    logic       i_op_ready;
    logic [7:0] o_op_a, o_op_b;
    logic [2:0] o_op_rd;
    logic       o_op_wr_en;
    logic       i_wb_valid;
    logic [2:0] i_wb_rd;
    logic [7:0] i_wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    operand_fetch dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_instr_valid   (i_instr_valid),
        .o_instr_ready   (o_instr_ready),
        .i_rs1           (i_rs1),
        .i_rs2           (i_rs2),
        .i_rd            (i_rd),
        .i_wr_en         (i_wr_en),
        .o_rf_r_address1 (o_rf_r_address1),
        .o_rf_r_address2 (o_rf_r_address2),
        .o_rf_read       (o_rf_read),
        .i_rf_data1      (i_rf_data1),
        .i_rf_data2      (i_rf_data2),
        .o_rf_w_address  (o_rf_w_address),
        .o_rf_w_data     (o_rf_w_data),
        .o_rf_write      (o_rf_write),
        .o_op_valid      (o_op_valid),
        .i_op_ready      (i_op_ready),
        .o_op_a          (o_op_a),
        .o_op_b          (o_op_b),
        .o_op_rd         (o_op_rd),
        .o_op_wr_en      (o_op_wr_en),
        .i_wb_valid      (i_wb_valid),
        .i_wb_rd         (i_wb_rd),
        .i_wb_data       (i_wb_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Register file model: synchronous read, old data on read-during-write.
    logic [7:0] rf_mem [8];
    always @(posedge i_clk) begin
        if (o_rf_write) rf_mem[o_rf_w_address] <= o_rf_w_data;
        if (o_rf_read) begin
            i_rf_data1 <= rf_mem[o_rf_r_address1];
            i_rf_data2 <= rf_mem[o_rf_r_address2];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic present(input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [2:0] rd, input logic wr);
        i_instr_valid = 1'b1;
        i_rs1 = rs1;
        i_rs2 = rs2;
        i_rd = rd;
        i_wr_en = wr;
        step();
        i_instr_valid = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] rd, input logic [7:0] data);
        i_wb_valid = 1'b1;
        i_wb_rd = rd;
        i_wb_data = data;
        step();
        i_wb_valid = 1'b0;
    endtask

    task automatic handoff();
        i_op_ready = 1'b1;
        step();
        i_op_ready = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_instr_valid = 1'b0;
        i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_wr_en = 1'b0;
        i_op_ready = 1'b0;
        i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
        step();
        check("rst_instr_ready", o_instr_ready, 1);
        check("rst_op_valid", o_op_valid, 0);
        check("rst_rf_read", o_rf_read, 0);
        check("rst_op_a", o_op_a, 0);
        check("rst_op_b", o_op_b, 0);
        check("rst_op_rd", o_op_rd, 0);
        check("rst_op_wr_en", o_op_wr_en, 0);
        check("rst_pending", dut.u_scoreboard.pending_q, 0);
        i_rst = 1'b0;
        step();
        check("post_rst_ready", o_instr_ready, 1);

        // Preload registers through the writeback pass-through.
        i_wb_valid = 1'b1; i_wb_rd = 3'd1; i_wb_data = 8'h11;
        #1;
        check("wb_pass_en", o_rf_write, 1);
        check("wb_pass_addr", o_rf_w_address, 1);
        check("wb_pass_data", o_rf_w_data, 8'h11);
        step();
        i_wb_valid = 1'b0;
        wb_write(3'd2, 8'h22);
        wb_write(3'd4, 8'h44);
        check("wb_nonpending_keeps", dut.u_scoreboard.pending_q, 0);

        // Basic issue: r1 + r2 -> r3
        present(3'd1, 3'd2, 3'd3, 1'b1);
        check("s1_check_ready", o_instr_ready, 0);
        check("s1_check_read", o_rf_read, 1);
        check("s1_check_addr1", o_rf_r_address1, 1);
        check("s1_check_addr2", o_rf_r_address2, 2);
        check("s1_check_valid", o_op_valid, 0);
        step();
        check("s1_data_read", o_rf_read, 0);
        check("s1_data_valid", o_op_valid, 0);
        step();
        check("s1_valid", o_op_valid, 1);
        check("s1_op_a", o_op_a, 8'h11);
        check("s1_op_b", o_op_b, 8'h22);
        check("s1_op_rd", o_op_rd, 3);
        check("s1_op_wr_en", o_op_wr_en, 1);
        handoff();
        check("s1_idle_valid", o_op_valid, 0);
        check("s1_idle_ready", o_instr_ready, 1);
        check("s1_pending3", dut.u_scoreboard.pending_q, 8'h08);

        // RAW stall on r3 until its writeback
        present(3'd3, 3'd2, 3'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("s2_stall_read", o_rf_read, 0);
            check("s2_stall_ready", o_instr_ready, 0);
            if (i < 2) step();
        end
        wb_write(3'd3, 8'h5A);
        check("s2_read_after_wb", o_rf_read, 1);
        check("s2_read_addr1", o_rf_r_address1, 3);
        check("s2_pending_clear", dut.u_scoreboard.pending_q, 0);
        step();
        step();
        check("s2_valid", o_op_valid, 1);
        check("s2_op_a", o_op_a, 8'h5A);
        check("s2_op_b", o_op_b, 8'h22);
        check("s2_op_wr_en", o_op_wr_en, 0);

        // Back-pressure for 5 cycles with a stray instruction offered
        i_instr_valid = 1'b1;
        i_rs1 = 3'd7; i_rs2 = 3'd7; i_rd = 3'd7; i_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("s4_hold_valid", o_op_valid, 1);
            check("s4_hold_a", o_op_a, 8'h5A);
            check("s4_hold_b", o_op_b, 8'h22);
            check("s4_hold_rd", o_op_rd, 6);
            check("s4_hold_ready", o_instr_ready, 0);
        end
        i_instr_valid = 1'b0;
        handoff();
        check("s4_no_set", dut.u_scoreboard.pending_q, 0);
        step();
        check("s4_stray_ignored", o_instr_ready, 1);

        // Writeback on the read edge must beat the stale file value
        present(3'd1, 3'd4, 3'd0, 1'b0);
        check("s3_read_cycle", o_rf_read, 1);
        i_wb_valid = 1'b1; i_wb_rd = 3'd4; i_wb_data = 8'h77;
        step();
        i_wb_valid = 1'b0;
        step();
        check("s3_valid", o_op_valid, 1);
        check("s3_op_a", o_op_a, 8'h11);
        check("s3_op_b_fwd", o_op_b, 8'h77);
        handoff();

        // rs1 == rs2 with writeback during DATA forwards both
        present(3'd2, 3'd2, 3'd0, 1'b0);
        step();
        wb_write(3'd2, 8'h99);
        check("s3b_op_a_fwd", o_op_a, 8'h99);
        check("s3b_op_b_fwd", o_op_b, 8'h99);
        handoff();

        // Set and clear of pending[5] on the same edge
        present(3'd1, 3'd1, 3'd5, 1'b1);
        step();
        step();
        check("s5_valid", o_op_valid, 1);
        i_op_ready = 1'b1;
        i_wb_valid = 1'b1; i_wb_rd = 3'd5; i_wb_data = 8'h55;
        step();
        i_op_ready = 1'b0;
        i_wb_valid = 1'b0;
        check("s5_set_wins", dut.u_scoreboard.pending_q, 8'h20);
        wb_write(3'd7, 8'h70);
        check("s5_other_wb", dut.u_scoreboard.pending_q, 8'h20);
        wb_write(3'd5, 8'h56);
        check("s5_cleared", dut.u_scoreboard.pending_q, 0);

        // Reset during DATA discards the in-flight instruction
        present(3'd1, 3'd2, 3'd3, 1'b1);
        step();
        step();
        handoff();
        check("s6_pre_pending", dut.u_scoreboard.pending_q, 8'h08);
        present(3'd4, 3'd1, 3'd2, 1'b1);
        step();
        check("s6_in_data", o_op_valid, 0);
        i_rst = 1'b1;
        #1;
        check("s6_rst_op_a", o_op_a, 0);
        check("s6_rst_op_b", o_op_b, 0);
        check("s6_rst_op_rd", o_op_rd, 0);
        check("s6_rst_op_wr_en", o_op_wr_en, 0);
        check("s6_rst_valid", o_op_valid, 0);
        check("s6_rst_read", o_rf_read, 0);
        check("s6_rst_addr1", o_rf_r_address1, 0);
        check("s6_rst_addr2", o_rf_r_address2, 0);
        check("s6_rst_pending", dut.u_scoreboard.pending_q, 0);
        step();
        i_rst = 1'b0;
        step();
        check("s6_post_ready", o_instr_ready, 1);
        check("s6_no_handoff", o_op_valid, 0);
        step();
        check("s6_still_idle", o_instr_ready, 1);
        check("s6_still_no_valid", o_op_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
